// File: rtl/warmboot_pkg.sv
// Shared types and constants for the warm-boot controller.
package warmboot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SETUP,
    FIRE,
    DONE
  } state_t;

  // Image index as driven onto {S1,S0}
  typedef logic [1:0] image_t;

  localparam image_t IMG_0 = 2'd0;
  localparam image_t IMG_1 = 2'd1;
  localparam image_t IMG_2 = 2'd2;
  localparam image_t IMG_3 = 2'd3;

  // Largest of three counts, used to size the shared sequence counter
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/warmboot_prim.sv
// Wrapper around the iCE40 SB_WARMBOOT primitive.
// Synthesis (SYNTHESIS defined) instantiates the hard primitive; otherwise a
// behavioural stub counts BOOT rising edges per {S1,S0} value seen at the edge.
module warmboot_prim (
  input logic clk,
  input logic rst_n,
  input logic boot,
  input logic s1,
  input logic s0
);

`ifdef SYNTHESIS
  SB_WARMBOOT u_sb (
    .BOOT (boot),
    .S1   (s1),
    .S0   (s0)
  );
`else
  logic       boot_q;
  logic [7:0] img_edges [4];

  // Log each BOOT rising edge against the image selected at that edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_q <= 1'b0;
      for (int k = 0; k < 4; k++) img_edges[k] <= 8'd0;
    end else begin
      boot_q <= boot;
      if (boot && !boot_q) img_edges[{s1, s0}] <= img_edges[{s1, s0}] + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/warmboot_ctrl.sv
// Warm-boot sequencer: accepts a reboot request with an image index, holds
// S1/S0 stable for SETUP_CYCLES, then pulses BOOT for BOOT_HOLD cycles and
// parks in DONE until reset.
// Optional macro WARMBOOT_ARM_EN: requires an ARM pulse before a request is
// accepted; an arm that is not used within ARM_TIMEOUT cycles expires and
// sets the sticky ERR flag.
module warmboot_ctrl
  import warmboot_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 16,
  parameter int unsigned BOOT_HOLD    = 8,
  parameter int unsigned ARM_TIMEOUT  = 2**20
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_valid,
  output logic   req_ready,
  input  image_t req_image,
  input  logic   arm,
  output logic   busy,
  output logic   err,
  output logic   wb_s1,
  output logic   wb_s0,
  output logic   wb_boot
);

  localparam int unsigned CNT_W = $clog2(max3(SETUP_CYCLES, BOOT_HOLD, ARM_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(BOOT_HOLD - 1);
`ifdef WARMBOOT_ARM_EN
  localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_TIMEOUT - 1);
`else
  logic arm_unused;
  assign arm_unused = arm;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  image_t           sel_q, sel_d;
  logic             boot_q, boot_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             accept_c;

  assign accept_c = req_valid & ready_q;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= IMG_0;
      boot_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      boot_q  <= boot_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Next state and next registered output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    boot_d  = 1'b0;
    busy_d  = busy_q;
    ready_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
`ifdef WARMBOOT_ARM_EN
        if (arm) begin
          state_d = ARMED;
          cnt_d   = '0;
          err_d   = 1'b0;
          ready_d = 1'b1;
        end
`else
        if (accept_c) begin
          state_d = SETUP;
          cnt_d   = '0;
          sel_d   = req_image;
          busy_d  = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
`endif
      end
      ARMED: begin
`ifdef WARMBOOT_ARM_EN
        if (accept_c) begin
          state_d = SETUP;
          cnt_d   = '0;
          sel_d   = req_image;
          busy_d  = 1'b1;
        end else if (arm) begin
          cnt_d   = '0;
          ready_d = 1'b1;
        end else if (cnt_q == ARM_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          ready_d = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = FIRE;
          cnt_d   = '0;
          boot_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIRE: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          boot_d = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign wb_s1     = sel_q[1];
  assign wb_s0     = sel_q[0];
  assign wb_boot   = boot_q;

  warmboot_prim u_prim (
    .clk   (clk),
    .rst_n (rst_n),
    .boot  (boot_q),
    .s1    (sel_q[1]),
    .s0    (sel_q[0])
  );

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Bench for warmboot_ctrl: two instances (default timing and 1/1 timing)
// share stimulus; an event/age model predicts every output each cycle.
module tb_warmboot_ctrl;
  import warmboot_pkg::*;

  localparam int S_A   = 16;
  localparam int B_A   = 8;
  localparam int S_B   = 1;
  localparam int B_B   = 1;
  localparam int T_ARM = 100;

  logic   clk       = 1'b0;
  logic   rst_n     = 1'b0;
  logic   req_valid = 1'b0;
  image_t req_image = IMG_0;
  logic   arm       = 1'b0;

  logic ready_a, busy_a, err_a, s1_a, s0_a, boot_a;
  logic ready_b, busy_b, err_b, s1_b, s0_b, boot_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  warmboot_ctrl #(.SETUP_CYCLES(S_A), .BOOT_HOLD(B_A), .ARM_TIMEOUT(T_ARM)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
    .req_image(req_image), .arm(arm), .busy(busy_a), .err(err_a),
    .wb_s1(s1_a), .wb_s0(s0_a), .wb_boot(boot_a));

  warmboot_ctrl #(.SETUP_CYCLES(S_B), .BOOT_HOLD(B_B), .ARM_TIMEOUT(T_ARM)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
    .req_image(req_image), .arm(arm), .busy(busy_b), .err(err_b),
    .wb_s1(s1_b), .wb_s0(s0_b), .wb_boot(boot_b));

  // Model: ages measured in cycles since the accept edge / last arm edge
  bit     m_up      = 1'b0;
  bit     m_acc     = 1'b0;
  bit     m_armed   = 1'b0;
  bit     m_err     = 1'b0;
  int     m_age     = 0;
  int     m_arm_age = 0;
  image_t m_img     = IMG_0;
  int     m_edges [2][4] = '{default: 0};

  function automatic bit exp_ready();
`ifdef WARMBOOT_ARM_EN
    return !m_acc && m_armed;
`else
    return !m_acc && m_up;
`endif
  endfunction

  function automatic bit in_win(input int s, input int b);
    return m_acc && (m_age >= s + 1) && (m_age <= s + b);
  endfunction

  function automatic image_t exp_sel();
    return m_acc ? m_img : IMG_0;
  endfunction

  // Model update on each edge / async reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_up <= 1'b0; m_acc <= 1'b0; m_armed <= 1'b0; m_err <= 1'b0;
      m_age <= 0; m_arm_age <= 0; m_img <= IMG_0;
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 4; k++) m_edges[i][k] <= 0;
    end else begin
      m_up <= 1'b1;
      if (m_acc) begin
        m_age <= m_age + 1;
        if (m_age == S_A + 1) m_edges[0][m_img] <= m_edges[0][m_img] + 1;
        if (m_age == S_B + 1) m_edges[1][m_img] <= m_edges[1][m_img] + 1;
      end else if (exp_ready() && req_valid) begin
        m_acc <= 1'b1; m_age <= 1; m_img <= req_image; m_armed <= 1'b0;
      end
`ifdef WARMBOOT_ARM_EN
      else if (m_armed) begin
        if (arm) m_arm_age <= 1;
        else if (m_arm_age == T_ARM) begin m_armed <= 1'b0; m_err <= 1'b1; end
        else m_arm_age <= m_arm_age + 1;
      end else if (arm) begin
        m_armed <= 1'b1; m_arm_age <= 1; m_err <= 1'b0;
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("ready_a", 32'(ready_a), 32'(exp_ready()));
    chk("ready_b", 32'(ready_b), 32'(exp_ready()));
    chk("busy_a", 32'(busy_a), 32'(m_acc));
    chk("busy_b", 32'(busy_b), 32'(m_acc));
    chk("err_a", 32'(err_a), 32'(m_err));
    chk("err_b", 32'(err_b), 32'(m_err));
    chk("sel_a", 32'({s1_a, s0_a}), 32'(exp_sel()));
    chk("sel_b", 32'({s1_b, s0_b}), 32'(exp_sel()));
    chk("boot_a", 32'(boot_a), 32'(in_win(S_A, B_A)));
    chk("boot_b", 32'(boot_b), 32'(in_win(S_B, B_B)));
    for (int k = 0; k < 4; k++) begin
      chk("edges_a", 32'(dut_a.u_prim.img_edges[k]), 32'(m_edges[0][k]));
      chk("edges_b", 32'(dut_b.u_prim.img_edges[k]), 32'(m_edges[1][k]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  int vpct, apct;

  initial begin
    // Reset values
    tick();
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_boot", 32'(boot_a), 32'd0);
    chk("rst_sel", 32'({s1_a, s0_a}), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    rst_n = 1'b1;
    tick();
`ifdef WARMBOOT_ARM_EN
    // Arm, then request image 3 fifty cycles later
    chk("idle_ready_armen", 32'(ready_a), 32'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("armed_ready", 32'(ready_a), 32'd1);
    repeat (49) tick();
    req_valid = 1'b1; req_image = IMG_3;
    tick();
    req_valid = 1'b0;
    chk("arm_acc_busy", 32'(busy_a), 32'd1);
    chk("arm_acc_sel", 32'({s1_a, s0_a}), 32'd3);
    repeat (16) tick();
    chk("arm_boot", 32'(boot_a), 32'd1);
    // Arm with no request: expiry
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (99) tick();
    chk("to_err_c100", 32'(err_a), 32'd0);
    chk("to_ready_c100", 32'(ready_a), 32'd1);
    tick();
    chk("to_err_c101", 32'(err_a), 32'd1);
    chk("to_ready_c101", 32'(ready_a), 32'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("rearm_err", 32'(err_a), 32'd0);
    chk("rearm_ready", 32'(ready_a), 32'd1);
`else
    // Request image 2, then a competing image-1 request during SETUP
    req_valid = 1'b1; req_image = IMG_2;
    chk("c0_ready", 32'(ready_a), 32'd1);
    tick();
    req_image = IMG_1;
    chk("c1_s1", 32'(s1_a), 32'd1);
    chk("c1_s0", 32'(s0_a), 32'd0);
    chk("c1_busy", 32'(busy_a), 32'd1);
    chk("c1_ready", 32'(ready_a), 32'd0);
    chk("c1_boot_b", 32'(boot_b), 32'd0);
    for (int c = 2; c <= 30; c++) begin
      tick();
      if (c == 2)  chk("c2_boot_b", 32'(boot_b), 32'd1);
      if (c == 3)  chk("c3_boot_b", 32'(boot_b), 32'd0);
      if (c == 10) chk("c10_sel", 32'({s1_a, s0_a}), 32'd2);
      if (c == 16) chk("c16_boot", 32'(boot_a), 32'd0);
      if (c == 17) chk("c17_boot", 32'(boot_a), 32'd1);
      if (c == 24) chk("c24_boot", 32'(boot_a), 32'd1);
      if (c == 25) begin
        chk("c25_boot", 32'(boot_a), 32'd0);
        chk("c25_busy", 32'(busy_a), 32'd1);
      end
      if (c == 26) begin
        chk("stub_a_img2", 32'(dut_a.u_prim.img_edges[2]), 32'd1);
        chk("stub_a_img1", 32'(dut_a.u_prim.img_edges[1]), 32'd0);
        chk("stub_b_img2", 32'(dut_b.u_prim.img_edges[2]), 32'd1);
      end
    end
    req_valid = 1'b0;
    // Reset during the third BOOT cycle
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    req_valid = 1'b1; req_image = IMG_3;
    tick();
    req_valid = 1'b0;
    repeat (18) tick();
    chk("c19_boot", 32'(boot_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_boot", 32'(boot_a), 32'd0);
    chk("async_busy", 32'(busy_a), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(ready_a), 32'd1);
    chk("post_rst_sel", 32'({s1_a, s0_a}), 32'd0);
`endif
    // Randomized phase with varying request/arm densities
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      tick();
      case ((i / 500) % 3)
        0:       begin vpct = 70; apct = 5; end
        1:       begin vpct = 2;  apct = 3; end
        default: begin vpct = 30; apct = 1; end
      endcase
      rst_n     = ($urandom_range(0, 199) != 0);
      req_valid = ($urandom_range(0, 99) < vpct);
      req_image = 2'($urandom_range(0, 3));
      arm       = ($urandom_range(0, 99) < apct);
    end
    rst_n = 1'b1; req_valid = 1'b0; arm = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
